logic_op_arbiter: RTL and testbench

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_pkg.sv | 27 ++
 rtl/logic_op_alu.sv | 37 +++
 rtl/logic_op_arbiter.sv | 134 +++++++++++++
 tb/tb_logic_op_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// logic_op_pkg
//   Shared definitions for the logic-op arbiter slice:
//     op_e       - 3-bit opcode map of the logic unit
//     state_e    - arbiter FSM states
//     OP_COUNT_W - width of the saturating completion counter
package logic_op_pkg;

  localparam int OP_COUNT_W = 16;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NOT     = 3'd2,  // operand b ignored
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7   // result forced to zero, err raised
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_alu.sv
// logic_op_alu
//   Purely combinational W-bit bitwise logic unit.
//   Ports:
//     a, b : operands (b unused for OP_NOT)
//     op   : opcode (logic_op_pkg::op_e)
//     y    : result, zero for the illegal opcode
//     err  : high only for the illegal opcode
module logic_op_alu
  import logic_op_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
//   NREQ requesters share one logic unit. A round-robin arbiter grants one
//   request in IDLE, the operation executes in EXEC, and the result is
//   presented in RESP until the consumer accepts it.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     req_valid/ready    : per-requester handshake (ready is one-hot or zero)
//     req_a, req_b       : packed operands, requester i at [i*W +: W]
//     req_op             : packed opcodes, requester i at [i*3 +: 3]
//     rsp_valid/ready    : result handshake
//     rsp_data/id/err    : result, owning requester, illegal-opcode flag
//     busy               : high whenever not IDLE
//     op_count           : saturating count of completed responses
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*3-1:0]        req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [OP_COUNT_W-1:0]    op_count
);

  localparam int ID_W = $clog2(NREQ);

  state_e          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            grant_any;
  logic            grant;
  int              rr_idx;

  logic [W-1:0]    cap_a, cap_b;
  op_e             cap_op;
  logic [ID_W-1:0] cap_id;

  logic [W-1:0]    alu_y;
  logic            alu_err;

  // Round-robin pick: walk upward from last_grant+1 with wrap; the first
  // valid requester met is the winner.
  always_comb begin
    winner    = last_grant;
    grant_any = 1'b0;
    rr_idx    = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = int'(last_grant) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      cand = ID_W'(rr_idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
  end

  assign grant = (state == ST_IDLE) && grant_any;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic_op_alu #(.W(W)) u_alu (
    .a   (cap_a),
    .b   (cap_b),
    .op  (cap_op),
    .y   (alu_y),
    .err (alu_err)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NREQ - 1);
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= OP_AND;
      cap_id     <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      // Operands are sampled only on the grant edge.
      if (grant) begin
        last_grant <= winner;
        cap_a      <= req_a[winner*W +: W];
        cap_b      <= req_b[winner*W +: W];
        cap_op     <= op_e'(req_op[winner*3 +: 3]);
        cap_id     <= winner;
      end
      if (state == ST_EXEC) begin
        rsp_data <= alu_y;
        rsp_id   <= cap_id;
        rsp_err  <= alu_err;
      end
      if (state == ST_RESP && rsp_ready && op_count != '1) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
module tb_logic_op_arbiter;
  import logic_op_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic [NREQ*3-1:0]   req_op;
  logic                rsp_valid, rsp_ready;
  logic [W-1:0]        rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_err, busy;
  logic [15:0]         op_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic_op_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a transaction is either outstanding or not; a granted
  // request becomes visible two cycles after its grant and retires when the
  // consumer accepts it.
  bit           m_pending;
  int           m_age;
  int           m_last;
  int           m_count;
  int           m_id;
  logic [W-1:0] m_data;
  bit           m_err;

  function automatic void model_op(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] y,
                                   output bit e);
    e = 1'b0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = ~a;
      3'd3: y = ~(a & b);
      3'd4: y = ~(a | b);
      3'd5: y = a ^ b;
      3'd6: y = ~(a ^ b);
      default: begin y = '0; e = 1'b1; end
    endcase
  endfunction

  logic [NREQ-1:0] exp_ready;
  int              pick;
  int              idx;
  bit              exp_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data",  rsp_data,  0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_rsp_err",   rsp_err,   0);
      check("rst_busy",      busy,      0);
      check("rst_op_count",  op_count,  0);
      m_pending = 1'b0;
      m_age     = 0;
      m_last    = NREQ - 1;
      m_count   = 0;
    end else begin
      exp_ready = '0;
      pick      = -1;
      if (!m_pending) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (pick < 0 && req_valid[idx]) pick = idx;
        end
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
      exp_valid = m_pending && (m_age >= 2);

      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("busy",      busy,      m_pending);
      check("op_count",  op_count,  m_count);
      if (exp_valid) begin
        check("rsp_data", rsp_data, m_data);
        check("rsp_id",   rsp_id,   m_id);
        check("rsp_err",  rsp_err,  m_err);
      end

      if (exp_valid && rsp_ready) begin
        m_pending = 1'b0;
        if (m_count < 65535) m_count++;
      end else if (m_pending) begin
        m_age++;
      end else if (pick >= 0) begin
        m_pending = 1'b1;
        m_age     = 1;
        m_last    = pick;
        m_id      = pick;
        model_op(req_op[pick*3 +: 3], req_a[pick*W +: W], req_b[pick*W +: W], m_data, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    req_valid[i]        = 1'b1;
    req_op[i*3 +: 3]    = op;
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
  endtask

  // Waits for requester i to be granted, steps over the grant edge, drops valid.
  task automatic await_grant(input int i, output int gcyc);
    gcyc = -1;
    for (int n = 0; n < 20 && gcyc < 0; n++) begin
      @(negedge clk);
      if (req_ready[i] === 1'b1) gcyc = cyc;
    end
    check("grant_seen", (gcyc >= 0), 1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with rsp_valid high.
  task automatic await_rsp(output int rcyc);
    rcyc = -1;
    for (int n = 0; n < 20 && rcyc < 0; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rcyc = cyc;
    end
    check("rsp_seen", (rcyc >= 0), 1);
  endtask

  task automatic do_op(input int i, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_data,
                       input bit exp_err, input int exp_count);
    int g, r;
    drive_req(i, op, a, b);
    await_grant(i, g);
    await_rsp(r);
    check("lit_latency", r - g, 2);
    check("lit_data",    rsp_data, exp_data);
    check("lit_id",      rsp_id,   i);
    check("lit_err",     rsp_err,  exp_err);
    tick();
    @(negedge clk);
    check("lit_count",   op_count, exp_count);
    check("lit_idle",    rsp_valid, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int g, r, prev;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single AND, NOT, illegal opcode
    do_op(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
    do_op(0, 3'd2, 8'h5A, 8'hFF, 8'hA5, 1'b0, 2);
    do_op(2, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 3);

    // Backpressure: five cycles with the consumer stalled
    rsp_ready = 1'b0;
    drive_req(1, 3'd5, 8'hA5, 8'h0F);
    await_grant(1, g);
    await_rsp(r);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data",  rsp_data,  8'hAA);
      check("bp_ready", req_ready, 0);
      check("bp_count", op_count,  3);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_done_count", op_count, 4);
    check("bp_done_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("bp_single_completion", op_count, 4);
    tick();

    // Reset during EXEC drops the operation
    drive_req(3, 3'd1, 8'h0F, 8'hF0);
    await_grant(3, g);
    rst_n = 1'b0;
    @(negedge clk);
    check("rx_valid", rsp_valid, 0);
    check("rx_busy",  busy,      0);
    check("rx_count", op_count,  0);
    tick();
    tick();
    rst_n = 1'b1;
    drive_req(0, 3'd1, 8'h11, 8'h22);
    drive_req(3, 3'd6, 8'h0F, 8'h33);
    @(negedge clk);
    check("rx_first_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    await_rsp(r);
    check("rx_req0_data", rsp_data, 8'h33);
    tick();
    await_grant(3, g);
    await_rsp(r);
    check("rx_req3_data", rsp_data, 8'hC3);
    tick();
    @(negedge clk);
    check("rx_count2", op_count, 2);
    tick();

    // Contention: all four held valid, grants 0,1,2,3,0 three cycles apart
    drive_req(0, 3'd1, 8'h81, 8'h18);
    drive_req(1, 3'd3, 8'hF0, 8'hCC);
    drive_req(2, 3'd4, 8'h0C, 8'h30);
    drive_req(3, 3'd6, 8'h55, 8'h0F);
    prev = -1;
    for (int n = 0; n < 5; n++) begin
      g = -1;
      for (int t = 0; t < 20 && g < 0; t++) begin
        @(negedge clk);
        if (req_ready !== '0) g = cyc;
      end
      check("ct_grant_seen", (g >= 0), 1);
      check("ct_grant", req_ready, (4'b0001 << order[n]));
      if (prev >= 0) check("ct_gap", g - prev, 3);
      prev = g;
      tick();
    end
    req_valid = '0;
    await_rsp(r);
    check("ct_last_id", rsp_id, 0);
    tick();
    repeat (3) tick();
    @(negedge clk);
    check("ct_count", op_count, 7);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
